// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Sequences a shared instruction/data memory
// and the datapath enables/muxes state by state. Memory states stretch
// until mem_ready; op/funct come straight from the stable IR.
module mips_multicycle_ctrl #(
  parameter logic [2:0] RTYPE_DEFAULT_ALU = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [2:0] alucontrol,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state;
  state_t state_next;

  assign state_o = state;

  // State register; reset drops straight back to FETCH, even mid-access.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  // Next-state: decode op in DECODE/MEMADR, hold memory states until ready.
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:     state_next = MEMADR;
          OP_RTYPE:         state_next = EXEC;
          OP_BEQ, OP_BNE:   state_next = BRANCH;
          OP_ADDI, OP_ORI:  state_next = IEXEC;
          OP_J:             state_next = JUMP;
          default:          state_next = FETCH;
        endcase
      end
      MEMADR: state_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_next = mem_ready ? MEMWB : MEMRD;
      MEMWB:  state_next = FETCH;
      MEMWR:  state_next = mem_ready ? FETCH : MEMWR;
      EXEC:   state_next = ALUWB;
      ALUWB:  state_next = FETCH;
      BRANCH: state_next = FETCH;
      IEXEC:  state_next = IWB;
      IWB:    state_next = FETCH;
      JUMP:   state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Outputs: Moore decode of state, with irwrite/pcen qualified by
  // mem_ready/zero and suppressed while reset is held.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroext    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alucontrol = 3'b010;
    case (state)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready & reset;
        pcen    = mem_ready & reset;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = RTYPE_DEFAULT_ALU;
        endcase
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen       = zero ^ (op == OP_BNE);
      end
      IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_ORI) begin
          alucontrol = 3'b001;
          zeroext    = 1'b1;
        end
      end
      IWB: begin
        regwrite = 1'b1;
        if (op == OP_ORI) begin
          alucontrol = 3'b001;
          zeroext    = 1'b1;
        end
      end
      JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl: walks each instruction class
// through its state sequence and checks outputs against hand-derived values.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       memread, memwrite, iord, irwrite, pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       zeroext, regdst, memtoreg, regwrite;
  logic [2:0] alucontrol;
  logic [3:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .memread    (memread),
    .memwrite   (memwrite),
    .iord       (iord),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .zeroext    (zeroext),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alucontrol (alucontrol),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step;
    @(posedge clk);
    #1;
    check("mem_excl", 32'(memread & memwrite), 32'd0);
  endtask

  // From FETCH with mem_ready=1, go to DECODE.
  task automatic to_decode(input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
    mem_ready = 1'b1;
    check("fetch_state", 32'(state_o), 32'd0);
    step();
    check("decode_state", 32'(state_o), 32'd1);
    check("decode_srcb", 32'(alusrcb), 32'd3);
    check("decode_pcen", 32'(pcen), 32'd0);
  endtask

  logic [5:0] rt_funct [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
  logic [2:0] rt_alu   [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
  logic [5:0] br_op    [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
  logic       br_zero  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic       br_pcen  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b0;
    op = 6'b0;
    funct = 6'b0;
    zero = 1'b0;
    mem_ready = 1'b1;
    #2;
    // Reset outputs, with mem_ready high to prove pcen/irwrite are gated.
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_memread", 32'(memread), 32'd1);
    check("rst_alusrcb", 32'(alusrcb), 32'd1);
    check("rst_aluctl", 32'(alucontrol), 32'd2);
    check("rst_pcen", 32'(pcen), 32'd0);
    check("rst_irwrite", 32'(irwrite), 32'd0);
    check("rst_memwrite", 32'(memwrite), 32'd0);
    check("rst_regwrite", 32'(regwrite), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_state", 32'(state_o), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("fetch_pcen", 32'(pcen), 32'd1);
    check("fetch_irwrite", 32'(irwrite), 32'd1);

    // lw: 0,1,2,3,4,0
    to_decode(6'b100011, 6'b0);
    check("lw_dec_regwrite", 32'(regwrite), 32'd0);
    step();
    check("lw_memadr", 32'(state_o), 32'd2);
    check("lw_memadr_srca", 32'(alusrca), 32'd1);
    check("lw_memadr_srcb", 32'(alusrcb), 32'd2);
    step();
    check("lw_memrd", 32'(state_o), 32'd3);
    check("lw_memrd_rd_iord", 32'({memread, iord, regwrite}), 32'b110);
    step();
    check("lw_memwb", 32'(state_o), 32'd4);
    check("lw_memwb_wr", 32'({regwrite, memtoreg, regdst, pcen}), 32'b1100);
    step();
    check("lw_back_fetch", 32'(state_o), 32'd0);

    // FETCH stall
    mem_ready = 1'b0;
    #1;
    check("stall_pcen", 32'(pcen), 32'd0);
    check("stall_irwrite", 32'(irwrite), 32'd0);
    step();
    check("stall_state", 32'(state_o), 32'd0);

    // sw with three wait cycles in MEMWR
    to_decode(6'b101011, 6'b0);
    step();
    check("sw_memadr", 32'(state_o), 32'd2);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("sw_memwr_state", 32'(state_o), 32'd5);
      check("sw_memwr_wr_iord", 32'({memwrite, iord, memread, regwrite}), 32'b1100);
    end
    mem_ready = 1'b1;
    #1;
    check("sw_memwr_last", 32'({memwrite, iord}), 32'b11);
    step();
    check("sw_back_fetch", 32'(state_o), 32'd0);
    check("sw_fetch_memwrite", 32'(memwrite), 32'd0);

    // R-type sweep
    for (int i = 0; i < 6; i++) begin
      to_decode(6'b000000, rt_funct[i]);
      step();
      check("rt_exec_state", 32'(state_o), 32'd6);
      check("rt_exec_alu", 32'(alucontrol), 32'(rt_alu[i]));
      check("rt_exec_src", 32'({alusrca, alusrcb}), 32'b100);
      step();
      check("rt_aluwb", 32'({state_o, regwrite, regdst, memtoreg}), 32'({4'd7, 3'b110}));
      step();
    end

    // Branches
    for (int i = 0; i < 4; i++) begin
      to_decode(br_op[i], 6'b0);
      zero = br_zero[i];
      step();
      check("br_state", 32'(state_o), 32'd8);
      check("br_pcen", 32'(pcen), 32'(br_pcen[i]));
      check("br_pcsrc_alu", 32'({pcsrc, alucontrol, regwrite}), 32'({2'b01, 3'b110, 1'b0}));
      step();
      zero = 1'b0;
    end

    // ori
    to_decode(6'b001101, 6'b0);
    step();
    check("ori_iexec", 32'({state_o, zeroext, alucontrol, regwrite}), 32'({4'd9, 1'b1, 3'b001, 1'b0}));
    step();
    check("ori_iwb", 32'({state_o, zeroext, alucontrol, regwrite, regdst}), 32'({4'd10, 1'b1, 3'b001, 2'b10}));
    step();

    // addi
    to_decode(6'b001000, 6'b0);
    step();
    check("addi_iexec", 32'({state_o, zeroext, alucontrol}), 32'({4'd9, 1'b0, 3'b010}));
    step();
    check("addi_iwb", 32'({regwrite, zeroext}), 32'b10);
    step();

    // j
    to_decode(6'b000010, 6'b0);
    step();
    check("j_jump", 32'({state_o, pcsrc, pcen, regwrite}), 32'({4'd11, 2'b10, 2'b10}));
    step();
    check("j_back_fetch", 32'(state_o), 32'd0);

    // Unknown op: DECODE then FETCH, no writes
    to_decode(6'b111111, 6'b0);
    check("nop_dec_writes", 32'({regwrite, memwrite}), 32'd0);
    step();
    check("nop_fetch", 32'(state_o), 32'd0);

    // Async reset mid-MEMWR
    to_decode(6'b101011, 6'b0);
    step();
    mem_ready = 1'b0;
    step();
    check("ar_memwr", 32'({state_o, memwrite}), 32'({4'd5, 1'b1}));
    #2 reset = 1'b0;
    #1;
    check("ar_state", 32'(state_o), 32'd0);
    check("ar_memwrite", 32'(memwrite), 32'd0);
    check("ar_memread", 32'(memread), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_rel_pcen", 32'(pcen), 32'd0);
    step();
    check("ar_rel_hold", 32'({state_o, pcen}), 32'd0);
    step();
    check("ar_rel_hold2", 32'(state_o), 32'd0);
    mem_ready = 1'b1;
    #1;
    check("ar_rel_pcen_ready", 32'(pcen), 32'd1);
    step();
    check("ar_rel_decode", 32'(state_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
